// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot transmitter states, parity modes and a parity helper.
package uart_pkg;

    localparam logic [4:0] TX_IDLE   = 5'b00001;
    localparam logic [4:0] TX_START  = 5'b00010;
    localparam logic [4:0] TX_DATA   = 5'b00100;
    localparam logic [4:0] TX_PARITY = 5'b01000;
    localparam logic [4:0] TX_STOP   = 5'b10000;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Even parity is the plain XOR; odd parity inverts it.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Modulo-OVERSAMPLE counter with synchronous clear; tick marks the last count of each bit.
module uart_baud_tick #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk_sample,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_sample or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_transmit.sv
// UART transmitter: write detect, one-deep holding register, shifter and framing FSM.
module uart_transmit
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk_sample,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       wrn,
    output logic       txd,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done
);

    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    logic [4:0] state, state_nxt;
    logic       tick;
    logic       wrn_d;
    logic       hold_full;
    logic [7:0] hold_q;
    logic [7:0] shift_q;
    logic       par_q;
    logic [2:0] bit_cnt;
    logic       stop_cnt;
    logic       txd_nxt;
    logic       write_evt;
    logic       frame_end;
    logic       load_shift;

    // A write is one falling edge of wrn while the holding register is empty.
    assign write_evt  = ~wrn & wrn_d & ~hold_full;
    assign frame_end  = (state == TX_STOP) && tick && (stop_cnt == STOP_LAST);
    assign load_shift = hold_full && ((state == TX_IDLE) || frame_end);
    assign tx_ready   = ~hold_full;

    uart_baud_tick #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_baud_tick (
        .clk_sample(clk_sample),
        .rst       (rst),
        .clr       (state == TX_IDLE),
        .tick      (tick)
    );

    always_ff @(posedge clk_sample or posedge rst) begin
        if (rst) begin
            state <= TX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TX_IDLE:   if (hold_full) state_nxt = TX_START;
            TX_START:  if (tick) state_nxt = TX_DATA;
            TX_DATA:   if (tick && (bit_cnt == 3'd7))
                           state_nxt = (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tick) state_nxt = TX_STOP;
            TX_STOP:   if (frame_end) state_nxt = hold_full ? TX_START : TX_IDLE;
            default:   state_nxt = TX_IDLE;
        endcase
    end

    // txd is registered, so its next value is chosen from the state being entered.
    always_comb begin
        busy    = (state != TX_IDLE);
        tx_done = frame_end;
        case (state_nxt)
            TX_START:  txd_nxt = 1'b0;
            TX_DATA:   txd_nxt = ((state == TX_DATA) && tick) ? shift_q[1] : shift_q[0];
            TX_PARITY: txd_nxt = par_q;
            default:   txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk_sample or posedge rst) begin
        if (rst) begin
            wrn_d     <= 1'b1;
            txd       <= 1'b1;
            hold_full <= 1'b0;
            hold_q    <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
        end else begin
            wrn_d <= wrn;
            txd   <= txd_nxt;

            if (write_evt) begin
                hold_q    <= din;
                hold_full <= 1'b1;
            end else if (load_shift) begin
                hold_full <= 1'b0;
            end

            if (load_shift) begin
                shift_q <= hold_q;
                par_q   <= parity_bit(hold_q, PARITY);
            end else if ((state == TX_DATA) && tick) begin
                shift_q <= {1'b0, shift_q[7:1]};
            end

            if (state != TX_DATA) begin
                bit_cnt <= '0;
            end else if (tick) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (state != TX_STOP) begin
                stop_cnt <= 1'b0;
            end else if (tick) begin
                stop_cnt <= ~stop_cnt;
            end
        end
    end

endmodule

// File: tb/tb_uart_transmit.sv
// Bench for uart_transmit: five parameter sets driven together, checked against a frame-timing model.
module tb_uart_transmit;

    localparam int N = 5;
    localparam int OS_A  [N] = '{16, 16, 16, 16, 5};
    localparam int PAR_A [N] = '{0, 2, 1, 0, 1};
    localparam int STP_A [N] = '{1, 1, 1, 2, 2};

    logic       clk_sample = 1'b0;
    logic       rst = 1'b1;
    logic       wrn = 1'b1;
    logic [7:0] din = 8'h00;
    logic       txd_w  [N];
    logic       rdy_w  [N];
    logic       busy_w [N];
    logic       done_w [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        uart_transmit #(
            .OVERSAMPLE(OS_A[g]),
            .PARITY    (PAR_A[g]),
            .STOP_BITS (STP_A[g])
        ) u_dut (
            .clk_sample(clk_sample),
            .rst       (rst),
            .din       (din),
            .wrn       (wrn),
            .txd       (txd_w[g]),
            .tx_ready  (rdy_w[g]),
            .busy      (busy_w[g]),
            .tx_done   (done_w[g])
        );
    end

    // ---------------- clock ----------------
    initial forever #5 clk_sample = ~clk_sample;

    // ---------------- reference model ----------------
    longint     cyc = 0;
    bit         wrn_prev;
    bit         frame_v [N];
    bit         hold_v  [N];
    longint     start_t [N];
    longint     hold_t  [N];
    logic [7:0] cur_b   [N];
    logic [7:0] hold_b  [N];
    logic [7:0] exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic int frame_len(input int i);
        return OS_A[i] * (9 + ((PAR_A[i] != 0) ? 1 : 0) + STP_A[i]);
    endfunction

    task automatic reset_model();
        for (int i = 0; i < N; i++) begin
            frame_v[i] = 1'b0;
            hold_v[i]  = 1'b0;
            start_t[i] = 0;
            hold_t[i]  = 0;
            cur_b[i]   = 8'h00;
            hold_b[i]  = 8'h00;
        end
        wrn_prev = 1'b1;
        exp_q.delete();
    endtask

    // Expected {txd, busy, tx_ready, tx_done} after edge t.
    function automatic logic [3:0] exp_out(input int i, input longint t);
        logic   line = 1'b1;
        logic   bsy  = 1'b0;
        logic   done = 1'b0;
        int     f    = frame_len(i);
        int     sym;
        if (frame_v[i] && (t >= start_t[i]) && (t < start_t[i] + f)) begin
            bsy = 1'b1;
            sym = int'((t - start_t[i]) / OS_A[i]);
            if (sym == 0) line = 1'b0;
            else if (sym <= 8) line = cur_b[i][sym-1];
            else if ((sym == 9) && (PAR_A[i] != 0))
                line = (PAR_A[i] == 2) ? ^cur_b[i] : ~^cur_b[i];
            done = (t == start_t[i] + f - 1);
        end
        return {line, bsy, ~hold_v[i], done};
    endfunction

    always @(posedge clk_sample) begin
        bit fall;
        bit acc;
        cyc++;
        if (!rst) begin
            fall = !wrn && wrn_prev;
            for (int i = 0; i < N; i++) begin
                acc = fall && !hold_v[i];
                if (hold_v[i] && (hold_t[i] == cyc)) begin
                    frame_v[i] = 1'b1;
                    start_t[i] = cyc;
                    cur_b[i]   = hold_b[i];
                    hold_v[i]  = 1'b0;
                end
                if (acc) begin
                    hold_v[i] = 1'b1;
                    hold_b[i] = din;
                    hold_t[i] = (frame_v[i] && (cyc < start_t[i] + frame_len(i)))
                                ? start_t[i] + frame_len(i) : cyc + 1;
                    if (i == 0) exp_q.push_back(din);
                end
            end
            wrn_prev = wrn;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    bit         rx_on = 1'b0;
    int         rx_pos = 0;
    logic [7:0] rx_byte = 8'h00;

    always @(posedge clk_sample) begin
        #3;
        for (int i = 0; i < N; i++)
            check($sformatf("out%0d", i),
                  {4'b0, txd_w[i], busy_w[i], rdy_w[i], done_w[i]},
                  {4'b0, exp_out(i, cyc)});
        // Mid-bit line decoder on the default-configuration instance.
        if (rst) begin
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if (txd_w[0] == 1'b0) begin
                rx_on   = 1'b1;
                rx_pos  = 0;
                rx_byte = 8'h00;
            end
        end else begin
            rx_pos++;
            if ((rx_pos % 16 == 8) && (rx_pos >= 24) && (rx_pos <= 136))
                rx_byte[(rx_pos - 24) / 16] = txd_w[0];
            if (rx_pos == 152) begin
                check("rx_stop", {7'b0, txd_w[0]}, 8'h01);
                check("rx_pending", (exp_q.size() > 0) ? 8'd1 : 8'd0, 8'd1);
                if (exp_q.size() > 0) check("rx_byte", rx_byte, exp_q.pop_front());
                rx_on = 1'b0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk_sample);
    endtask

    task automatic write_byte(input logic [7:0] b, input int low);
        @(negedge clk_sample);
        din = b;
        wrn = 1'b0;
        repeat (low) @(negedge clk_sample);
        wrn = 1'b1;
    endtask

    initial begin
        reset_model();
        rst = 1'b1;
        repeat (3) @(negedge clk_sample);
        rst = 1'b0;
        idle(5);

        write_byte(8'h55, 1);
        idle(200);

        write_byte(8'hA5, 1);
        idle(30);
        write_byte(8'h3C, 1);
        idle(20);
        write_byte(8'h99, 2);
        idle(450);

        write_byte(8'h07, 1);
        idle(250);

        write_byte(8'hFF, 500);
        idle(250);

        write_byte(8'h00, 1);
        idle(60);
        rst = 1'b1;
        reset_model();
        #1;
        for (int i = 0; i < N; i++)
            check($sformatf("rst_async%0d", i),
                  {4'b0, txd_w[i], busy_w[i], rdy_w[i], done_w[i]}, 8'b0000_1010);
        @(negedge clk_sample);
        rst = 1'b0;
        idle(200);

        for (int k = 0; k < 40; k++) begin
            write_byte(8'($urandom_range(0, 255)), $urandom_range(1, 4));
            idle($urandom_range(0, 220));
        end
        idle(500);

        check("exp_q_empty", 8'(exp_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
